// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer: state encoding,
// operation codes and default sizing.
package muldiv_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FIX  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a radix-2 Booth step for MULT or a restoring
// shift/subtract step for DIV, over the sequencer's working accumulators.
module muldiv_step
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             acc_q1,
  input  logic [WIDTH:0]   operand,
  output logic [WIDTH:0]   next_hi,
  output logic [WIDTH-1:0] next_lo,
  output logic             next_q1
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum     = acc_hi;
    shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    next_hi = acc_hi;
    next_lo = acc_lo;
    next_q1 = 1'b0;

    if (op == OP_MULT) begin
      // The high accumulator is one bit wider than the operand so that
      // subtracting the most negative multiplicand cannot overflow.
      unique case ({acc_lo[0], acc_q1})
        2'b01:   sum = acc_hi + operand;
        2'b10:   sum = acc_hi - operand;
        default: sum = acc_hi;
      endcase
      next_hi = {sum[WIDTH], sum[WIDTH:1]};
      next_lo = {sum[0], acc_lo[WIDTH-1:1]};
      next_q1 = acc_lo[0];
    end else begin
      if (shifted >= operand) begin
        next_hi = shifted - operand;
        next_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        next_hi = shifted;
        next_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle MULT/DIV sequencer for the Hi/Lo registers: start/busy/done
// handshake, WIDTH iterations, one sign-fix cycle, divide-by-zero and abort.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             hilo_load,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divby0
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;

  logic             op_q;
  logic             quot_neg;
  logic             rem_neg;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             acc_q1;
  logic [WIDTH:0]   mcand;

  logic [WIDTH:0]   step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             step_q1;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] rem_mag;
  logic             b_zero;
  logic             last_iter;

  // Magnitude of the most negative value is still correct read as unsigned.
  assign mag_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign mag_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign b_zero    = (operand_b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign rem_mag   = acc_hi[WIDTH-1:0];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .acc_q1  (acc_q1),
    .operand (mcand),
    .next_hi (step_hi),
    .next_lo (step_lo),
    .next_q1 (step_q1)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = (op == OP_DIV && b_zero) ? ST_ERR : ST_CALC;
      end
      ST_CALC: begin
        if (abort)          state_next = ST_IDLE;
        else if (last_iter) state_next = ST_FIX;
      end
      ST_FIX:  state_next = abort ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_CALC) cnt <= cnt + CNT_W'(1);
      else                  cnt <= '0;
    end
  end

  // NOTE: working registers carry no reset; they are loaded at start and are
  // only meaningful in CALC and FIX, so clearing them would buy nothing.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      op_q     <= op;
      quot_neg <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
      rem_neg  <= operand_a[WIDTH-1];
      acc_hi   <= '0;
      acc_q1   <= 1'b0;
      if (op == OP_MULT) begin
        acc_lo <= operand_b;
        mcand  <= {operand_a[WIDTH-1], operand_a};
      end else begin
        acc_lo <= mag_a;
        mcand  <= {1'b0, mag_b};
      end
    end else if (state == ST_CALC) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      acc_q1 <= step_q1;
    end
  end

  // Hi/Lo are the architecturally visible results; they move only in FIX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_FIX && !abort) begin
      if (op_q == OP_MULT) begin
        hi <= acc_hi[WIDTH-1:0];
        lo <= acc_lo;
      end else begin
        hi <= rem_neg  ? -rem_mag : rem_mag;
        lo <= quot_neg ? -acc_lo  : acc_lo;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) || (state == ST_ERR);
  assign hilo_load = (state == ST_DONE);
  assign divby0    = (state == ST_ERR);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed handshake, latency,
// abort, reset and divide-by-zero cases plus a few model-checked operations.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic         hilo_load;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         divby0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .hilo_load (hilo_load),
    .hi        (hi),
    .lo        (lo),
    .divby0    (divby0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: full-precision signed arithmetic; truncating division gives
  // a remainder with the dividend's sign.
  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.div0 = 1'b0;
    if (o == OP_MULT) begin
      p    = 64'(sa * sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
      q    = 64'(sa / sbv);
      r    = 64'(sa % sbv);
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  task automatic drive_start(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_exp(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
    exp_t e;
    e.hi   = eh;
    e.lo   = el;
    e.div0 = ed;
    sb_q.push_back(e);
    drive_start(o, a, b);
  endtask

  task automatic issue_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (o == OP_DIV && b == '0) begin
      e.hi   = last_hi;
      e.lo   = last_lo;
      e.div0 = 1'b1;
    end else begin
      e = model(o, a, b);
    end
    issue_exp(o, a, b, e.hi, e.lo, e.div0);
  endtask

  // Waits for done (bounded), then pops the scoreboard and compares. A
  // non-zero poke_at drives a competing start during that busy cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int poke_at);
    int   cyc = 0;
    bit   seen = 1'b0;
    bit   busy_ok = 1'b1;
    exp_t e;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (!busy) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      if (cyc == poke_at) begin
        start     = 1'b1;
        op        = OP_MULT;
        operand_a = 32'h1234_5678;
        operand_b = 32'h0000_0011;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " busy_held"}, 64'(busy_ok), 64'd1);
    check({tag, " sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    check({tag, " hi"}, 64'(hi), 64'(e.hi));
    check({tag, " lo"}, 64'(lo), 64'(e.lo));
    check({tag, " divby0"}, 64'(divby0), 64'(e.div0));
    check({tag, " hilo_load"}, 64'(hilo_load), 64'(!e.div0));
    @(negedge clk);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
    check({tag, " idle_done"}, 64'(done), 64'd0);
    if (!e.div0) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hilo_load", 64'(hilo_load), 64'd0);
    check("rst divby0", 64'(divby0), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);

    // Directed arithmetic, including the sign and overflow corners
    issue_exp(OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    wait_done("mul 7x-3", 34, 0);
    issue_exp(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    wait_done("mul min*min", 34, 0);
    issue_exp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    wait_done("div min/-1", 34, 0);
    issue_exp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done("div -7/2", 34, 0);
    issue_exp(OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    wait_done("div 100/-7", 34, 0);

    // Divide by zero keeps the previous Hi/Lo
    issue_exp(OP_DIV, 32'd5, 32'd0, 32'd2, 32'hFFFF_FFF2, 1'b1);
    wait_done("div 5/0", 1, 0);

    // Abort at CALC iteration 10: no completion, Hi/Lo untouched
    drive_start(OP_MULT, 32'd1000, 32'd3000);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort hilo_load", 64'(hilo_load), 64'd0);
    check("abort hi", 64'(hi), 64'(last_hi));
    check("abort lo", 64'(lo), 64'(last_lo));
    issue_model(OP_MULT, 32'd1000, 32'd3000);
    wait_done("after abort", 34, 0);

    // A second start while busy is ignored
    issue_model(OP_DIV, 32'd12345, 32'd67);
    wait_done("start while busy", 34, 5);

    // Asynchronous reset mid-DIV
    drive_start(OP_DIV, 32'd999_999, 32'd7);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hilo_load", 64'(hilo_load), 64'd0);
    check("midrst divby0", 64'(divby0), 64'd0);
    check("midrst hi", 64'(hi), 64'd0);
    check("midrst lo", 64'(lo), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    last_hi  = '0;
    last_lo  = '0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || hilo_load) done_cnt++;
    end
    check("midrst no_done", 64'(done_cnt), 64'd0);

    // Model-checked random operands
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 1 && rb == '0) rb = 32'd1;
      if (i % 3 == 2) rb = {{24{rb[7]}}, rb[7:0]} | 32'd1;
      issue_model((i % 2 == 1) ? OP_DIV : OP_MULT, ra, rb);
      wait_done((i % 2 == 1) ? "rand div" : "rand mul", 34, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
